// File: rtl/usr_serial_tx_ctrl.sv
// Serial transmitter sequencer: drives a 4-bit universal shift register to send
// a byte as a UART-style frame (start, 8 data bits LSB first, stop bits).
module usr_serial_tx_ctrl #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] usr_mode,
  output logic [3:0] usr_par_in,
  output logic       usr_si,
  input  logic       usr_so,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CC_W = $clog2(BIT_CYCLES + 1);
  localparam logic [CC_W-1:0] CC_LAST = CC_W'(BIT_CYCLES - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CC_W-1:0] cc_q, cc_d;
  logic [2:0]      bc_q, bc_d;
  logic [7:0]      byte_q, byte_d;
  logic            bit_end;

  assign bit_end  = (cc_q == CC_LAST);
  assign in_ready = (state_q == IDLE) & ~rst;
  assign usr_si   = 1'b0;

  // Next state, counters and USR control, all decoded from registered state.
  always_comb begin
    state_d    = state_q;
    cc_d       = cc_q;
    bc_d       = bc_q;
    byte_d     = byte_q;
    usr_mode   = MODE_HOLD;
    usr_par_in = 4'h0;
    tx         = 1'b1;
    busy       = (state_q != IDLE);
    done       = 1'b0;

    if (state_q != IDLE) begin
      cc_d = bit_end ? '0 : cc_q + CC_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          byte_d  = in_data;
          state_d = START;
          cc_d    = '0;
          bc_d    = 3'd0;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          usr_mode   = MODE_LOAD;
          usr_par_in = byte_q[3:0];
          state_d    = DATA;
        end
      end
      DATA: begin
        tx = usr_so;
        if (bit_end) begin
          bc_d = bc_q + 3'd1;
          // Low nibble is exhausted after bit 3; reload with the high nibble.
          case (bc_q)
            3'd3: begin
              usr_mode   = MODE_LOAD;
              usr_par_in = byte_q[7:4];
            end
            3'd7: begin
              usr_mode = MODE_HOLD;
              state_d  = STOP;
            end
            default: usr_mode = MODE_SHR;
          endcase
        end
      end
      STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          // bc counts stop bits here after wrapping out of DATA.
          if (bc_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
            bc_d    = 3'd0;
          end else begin
            bc_d = bc_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cc_q    <= '0;
      bc_q    <= 3'd0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      bc_q    <= bc_d;
      byte_q  <= byte_d;
    end
  end

endmodule

// File: tb/tb_usr_serial_tx_ctrl.sv
// Directed bench for usr_serial_tx_ctrl; three configurations, each paired with
// a behavioural 4-bit universal shift register.
module tb_usr_serial_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Instance a: BIT_CYCLES=4, STOP_BITS=1
  logic [7:0] in_data_a = 8'h00;
  logic in_valid_a = 1'b0, in_ready_a, si_a, so_a, tx_a, busy_a, done_a;
  logic [1:0] mode_a;
  logic [3:0] par_a, usr_q_a;
  // Instance b: BIT_CYCLES=1, STOP_BITS=1
  logic [7:0] in_data_b = 8'h00;
  logic in_valid_b = 1'b0, in_ready_b, si_b, so_b, tx_b, busy_b, done_b;
  logic [1:0] mode_b;
  logic [3:0] par_b, usr_q_b;
  // Instance c: BIT_CYCLES=2, STOP_BITS=2
  logic [7:0] in_data_c = 8'h00;
  logic in_valid_c = 1'b0, in_ready_c, si_c, so_c, tx_c, busy_c, done_c;
  logic [1:0] mode_c;
  logic [3:0] par_c, usr_q_c;

  usr_serial_tx_ctrl #(.BIT_CYCLES(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .usr_mode(mode_a), .usr_par_in(par_a), .usr_si(si_a), .usr_so(so_a),
    .tx(tx_a), .busy(busy_a), .done(done_a));
  usr_serial_tx_ctrl #(.BIT_CYCLES(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .usr_mode(mode_b), .usr_par_in(par_b), .usr_si(si_b), .usr_so(so_b),
    .tx(tx_b), .busy(busy_b), .done(done_b));
  usr_serial_tx_ctrl #(.BIT_CYCLES(2), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .usr_mode(mode_c), .usr_par_in(par_c), .usr_si(si_c), .usr_so(so_c),
    .tx(tx_c), .busy(busy_c), .done(done_c));

  // Behavioural USR models: 00 hold, 01 shift right, 10 shift left, 11 load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) usr_q_a <= 4'h0;
    else case (mode_a)
      2'b01: usr_q_a <= {si_a, usr_q_a[3:1]};
      2'b10: usr_q_a <= {usr_q_a[2:0], si_a};
      2'b11: usr_q_a <= par_a;
      default: usr_q_a <= usr_q_a;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) usr_q_b <= 4'h0;
    else case (mode_b)
      2'b01: usr_q_b <= {si_b, usr_q_b[3:1]};
      2'b10: usr_q_b <= {usr_q_b[2:0], si_b};
      2'b11: usr_q_b <= par_b;
      default: usr_q_b <= usr_q_b;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) usr_q_c <= 4'h0;
    else case (mode_c)
      2'b01: usr_q_c <= {si_c, usr_q_c[3:1]};
      2'b10: usr_q_c <= {usr_q_c[2:0], si_c};
      2'b11: usr_q_c <= par_c;
      default: usr_q_c <= usr_q_c;
    endcase
  end
  assign so_a = usr_q_a[0];
  assign so_b = usr_q_b[0];
  assign so_c = usr_q_c[0];

  task automatic test_reset();
    rst = 1'b1;
    in_valid_a = 1'b1;
    in_data_a  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if ({tx_a, mode_a, in_ready_a, busy_a, done_a} !== 6'b100000) begin
        nerr++;
        $display("FAIL reset cyc%0d {tx,mode,rdy,busy,done}: got %b want 100000",
                 i, {tx_a, mode_a, in_ready_a, busy_a, done_a});
      end
    end
    in_valid_a = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({in_ready_a, busy_a, tx_a} !== 3'b101) begin
      nerr++;
      $display("FAIL reset release {rdy,busy,tx}: got %b want 101", {in_ready_a, busy_a, tx_a});
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] fr;
    int loads;
    logic [3:0] par1, par2;
    fr = 10'b1101001010;
    loads = 0; par1 = 4'h0; par2 = 4'h0;
    in_data_a  = 8'hA5;
    in_valid_a = 1'b1;
    nvec++;
    if (in_ready_a !== 1'b1) begin
      nerr++;
      $display("FAIL single ready before accept: got %b want 1", in_ready_a);
    end
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      nvec++;
      if (tx_a !== fr[i/4] || done_a !== (i == 39) || busy_a !== 1'b1) begin
        nerr++;
        $display("FAIL single cyc%0d {tx,done,busy}: got %b%b%b want %b%b1",
                 i, tx_a, done_a, busy_a, fr[i/4], (i == 39));
      end
      if (mode_a == 2'b11) begin
        if (loads == 0) par1 = par_a; else par2 = par_a;
        loads++;
      end
      if (mode_a === 2'b10 || si_a !== 1'b0) begin
        nvec++; nerr++;
        $display("FAIL single invariant cyc%0d mode=%b si=%b", i, mode_a, si_a);
      end
    end
    nvec++;
    if (loads != 2 || par1 !== 4'h5 || par2 !== 4'hA) begin
      nerr++;
      $display("FAIL single loads: got n=%0d %h,%h want n=2 5,A", loads, par1, par2);
    end
    @(negedge clk);
    nvec++;
    if ({busy_a, in_ready_a, done_a, tx_a} !== 4'b0101) begin
      nerr++;
      $display("FAIL single post {busy,rdy,done,tx}: got %b want 0101",
               {busy_a, in_ready_a, done_a, tx_a});
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] fr0, fr1;
    logic exp_tx, exp_busy;
    fr0 = 10'b1000000000;
    fr1 = 10'b1111111110;
    in_data_b  = 8'h00;
    in_valid_b = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 0) in_data_b = 8'hFF;
      exp_tx   = (i < 10) ? fr0[i] : (i == 10) ? 1'b1 : (i < 21) ? fr1[i-11] : 1'b1;
      exp_busy = (i != 10) && (i != 21);
      nvec++;
      if (tx_b !== exp_tx || done_b !== (i == 9 || i == 20) || busy_b !== exp_busy ||
          in_ready_b !== !exp_busy) begin
        nerr++;
        $display("FAIL b2b cyc%0d {tx,done,busy,rdy}: got %b%b%b%b want %b%b%b%b",
                 i, tx_b, done_b, busy_b, in_ready_b,
                 exp_tx, (i == 9 || i == 20), exp_busy, !exp_busy);
      end
      if (i == 20) in_valid_b = 1'b0;
    end
  endtask

  task automatic test_busy_ignore();
    logic [9:0] fr;
    logic exp_tx;
    fr = 10'b1100000010;
    in_data_a  = 8'h81;
    in_valid_a = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      if (i == 10) begin
        in_data_a  = 8'h3C;
        in_valid_a = 1'b1;
        nvec++;
        if (in_ready_a !== 1'b0) begin
          nerr++;
          $display("FAIL busy ready during pulse: got %b want 0", in_ready_a);
        end
      end
      exp_tx = (i < 40) ? fr[i/4] : 1'b1;
      nvec++;
      if (tx_a !== exp_tx || done_a !== (i == 39) || busy_a !== (i < 40)) begin
        nerr++;
        $display("FAIL busy cyc%0d {tx,done,busy}: got %b%b%b want %b%b%b",
                 i, tx_a, done_a, busy_a, exp_tx, (i == 39), (i < 40));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] fr;
    fr = 10'b1010110100;
    in_data_a  = 8'h5A;
    in_valid_a = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      nvec++;
      if (tx_a !== fr[i/4] || done_a !== 1'b0) begin
        nerr++;
        $display("FAIL midrst pre cyc%0d {tx,done}: got %b%b want %b0", i, tx_a, done_a, fr[i/4]);
      end
    end
    rst = 1'b1;
    #1;
    nvec++;
    if ({tx_a, mode_a, busy_a, in_ready_a, done_a} !== 6'b100000) begin
      nerr++;
      $display("FAIL midrst async {tx,mode,busy,rdy,done}: got %b want 100000",
               {tx_a, mode_a, busy_a, in_ready_a, done_a});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nvec++;
      if (done_a !== 1'b0 || tx_a !== 1'b1) begin
        nerr++;
        $display("FAIL midrst hold cyc%0d {done,tx}: got %b%b want 01", i, done_a, tx_a);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    fr = 10'b1000100010;
    in_data_a  = 8'h11;
    in_valid_a = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      nvec++;
      if (tx_a !== ((i < 40) ? fr[i/4] : 1'b1) || done_a !== (i == 39)) begin
        nerr++;
        $display("FAIL midrst next cyc%0d {tx,done}: got %b%b want %b%b",
                 i, tx_a, done_a, ((i < 40) ? fr[i/4] : 1'b1), (i == 39));
      end
    end
  endtask

  task automatic test_two_stop_bits();
    logic [10:0] fr;
    logic exp_tx;
    fr = 11'b11100000000;
    in_data_c  = 8'h80;
    in_valid_c = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      in_valid_c = 1'b0;
      exp_tx = (i < 22) ? fr[i/2] : 1'b1;
      nvec++;
      if (tx_c !== exp_tx || done_c !== (i == 21) || busy_c !== (i < 22)) begin
        nerr++;
        $display("FAIL stop2 cyc%0d {tx,done,busy}: got %b%b%b want %b%b%b",
                 i, tx_c, done_c, busy_c, exp_tx, (i == 21), (i < 22));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_two_stop_bits();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
